// File: rtl/bus_arbiter_if.sv
// Master-side and pad-side signals of the two-master nibble bus arbiter.
// The slave modport is the arbiter's view; master is the view of the masters/pads.
interface bus_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 4
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_rw;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_rw;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_data_out;
  logic [DATA_W-1:0] bus_data_in;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  m0_req, m0_addr, m0_rw, m0_wdata,
    input  m1_req, m1_addr, m1_rw, m1_wdata,
    input  bus_data_in,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output bus_addr, bus_rw, bus_data_out, busy, grant_id
  );

  modport master (
    output m0_req, m0_addr, m0_rw, m0_wdata,
    output m1_req, m1_addr, m1_rw, m1_wdata,
    output bus_data_in,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  bus_addr, bus_rw, bus_data_out, busy, grant_id
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one external nibble bus between CPU (m0) and loader (m1).
// Fixed-length accesses of WAIT_CYCLES bus cycles, then a one-cycle ack to the winner.
module bus_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;
  logic              r_gid;
  logic              r_last;

  logic w_any;
  logic w_pick;

  // On a tie the master that did not win last time gets the bus.
  assign w_any  = bus.m0_req | bus.m1_req;
  assign w_pick = (bus.m0_req && bus.m1_req) ? ~r_last : bus.m1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_gid   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_rw   <= 1'b0;
          if (w_any) begin
            r_addr  <= w_pick ? bus.m1_addr  : bus.m0_addr;
            r_rw    <= w_pick ? bus.m1_rw    : bus.m0_rw;
            r_wdata <= w_pick ? bus.m1_wdata : bus.m0_wdata;
            r_gid   <= w_pick;
            r_last  <= w_pick;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            // Sample read data at the end of the last wait cycle; writes leave rdata alone.
            if (!r_rw) r_rdata <= bus.bus_data_in;
            r_rw    <= 1'b0;
            r_ack0  <= ~r_gid;
            r_ack1  <= r_gid;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_rw    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_addr     = r_addr;
  assign bus.bus_rw       = r_rw;
  assign bus.bus_data_out = r_wdata;
  assign bus.m0_rdata     = r_rdata;
  assign bus.m1_rdata     = r_rdata;
  assign bus.m0_ack       = r_ack0;
  assign bus.m1_ack       = r_ack1;
  assign bus.busy         = r_busy;
  assign bus.grant_id     = r_gid;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected acks, a monitor pops them.
// A second instance with WAIT_CYCLES=3 covers long accesses.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] model_rd = 4'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_arbiter_if #(.ADDR_W(11), .DATA_W(4)) if1 ();
  bus_arbiter_if #(.ADDR_W(11), .DATA_W(4)) if3 ();

  bus_arbiter #(.ADDR_W(11), .DATA_W(4), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst),  .bus(if1));
  bus_arbiter #(.ADDR_W(11), .DATA_W(4), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

  typedef struct {
    logic        id;
    logic [3:0]  rdata;
    logic [10:0] addr;
  } exp_t;
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_m(input bit m, input bit req, input logic [10:0] a, input bit rw,
                       input logic [3:0] wd);
    if (!m) begin
      if1.m0_req = req; if1.m0_addr = a; if1.m0_rw = rw; if1.m0_wdata = wd;
    end else begin
      if1.m1_req = req; if1.m1_addr = a; if1.m1_rw = rw; if1.m1_wdata = wd;
    end
  endtask

  function automatic logic ack_of(input bit m);
    return m ? if1.m1_ack : if1.m0_ack;
  endfunction

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if1.m0_ack || if1.m1_ack) begin
      chk("dual_ack", {31'd0, if1.m0_ack & if1.m1_ack}, 32'd0);
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none (cycle %0d)",
                 if1.m0_ack, if1.m1_ack, cyc);
      end else begin
        e = q1.pop_front();
        chk("ack_id",   {31'd0, if1.m1_ack}, {31'd0, e.id});
        chk("ack_rdata", {28'd0, (e.id ? if1.m1_rdata : if1.m0_rdata)}, {28'd0, e.rdata});
        chk("ack_addr", {21'd0, if1.bus_addr}, {21'd0, e.addr});
        chk("ack_busy", {31'd0, if1.busy}, 32'd1);
      end
    end
  end

  // Single transaction on dut1 with no competing request.
  task automatic txn(input bit m, input logic [10:0] a, input bit rw, input logic [3:0] wd,
                     input logic [3:0] din);
    exp_t e;
    e.id = m; e.addr = a; e.rdata = rw ? model_rd : din;
    if (!rw) model_rd = din;
    q1.push_back(e);
    @(posedge clk); #1;
    set_m(m, 1'b1, a, rw, wd);
    if1.bus_data_in = din;
    @(posedge clk);
    @(negedge clk);
    chk("acc_addr", {21'd0, if1.bus_addr}, {21'd0, a});
    chk("acc_rw",   {31'd0, if1.bus_rw}, {31'd0, rw});
    if (rw) chk("acc_wdata", {28'd0, if1.bus_data_out}, {28'd0, wd});
    chk("acc_busy", {31'd0, if1.busy}, 32'd1);
    chk("acc_gid",  {31'd0, if1.grant_id}, {31'd0, m});
    chk("acc_noack", {31'd0, ack_of(m)}, 32'd0);
    set_m(m, 1'b1, ~a, ~rw, ~wd);
    @(negedge clk);
    chk("ack_on_time", {31'd0, ack_of(m)}, 32'd1);
    chk("ack_rw_low",  {31'd0, if1.bus_rw}, 32'd0);
    set_m(m, 1'b0, ~a, 1'b0, ~wd);
    @(negedge clk);
    chk("idle_busy", {31'd0, if1.busy}, 32'd0);
    chk("idle_addr", {21'd0, if1.bus_addr}, {21'd0, a});
    chk("idle_rw",   {31'd0, if1.bus_rw}, 32'd0);
    chk("idle_ack",  {30'd0, if1.m0_ack, if1.m1_ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   acks, last_ack, rw_cnt, rw_first, rw_last, ack_at;
    exp_t e;
    set_m(0, 0, 11'h0, 0, 4'h0);
    set_m(1, 0, 11'h0, 0, 4'h0);
    if1.bus_data_in = 4'h0;
    if3.m0_req = 0; if3.m0_addr = '0; if3.m0_rw = 0; if3.m0_wdata = '0;
    if3.m1_req = 0; if3.m1_addr = '0; if3.m1_rw = 0; if3.m1_wdata = '0;
    if3.bus_data_in = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;

    // Idle after reset: everything at reset value, no acks.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("reset_idle", {if1.bus_addr, if1.bus_rw, if1.bus_data_out, if1.m0_rdata,
                         if1.busy, if1.grant_id, if1.m0_ack, if1.m1_ack}, 32'd0);
    end

    txn(1'b0, 11'h155, 1'b0, 4'h0, 4'hA);
    txn(1'b1, 11'h7FF, 1'b1, 4'h5, 4'h3);
    chk("rdata_after_write", {28'd0, if1.m0_rdata}, 32'hA);

    // Both masters hold req: grants alternate 0,1,0,1 every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      e.id = k[0]; e.rdata = 4'h3; e.addr = k[0] ? 11'h321 : 11'h0AA;
      q1.push_back(e);
    end
    model_rd = 4'h3;
    @(posedge clk); #1;
    set_m(0, 1, 11'h0AA, 0, 4'h0);
    set_m(1, 1, 11'h321, 0, 4'h0);
    if1.bus_data_in = 4'h3;
    acks = 0; last_ack = -1;
    for (int k = 0; k < 40 && acks < 4; k++) begin
      @(negedge clk);
      if (if1.m0_ack || if1.m1_ack) begin
        if (last_ack >= 0) chk("rr_period", cyc - last_ack, 32'd3);
        last_ack = cyc;
        acks++;
        if (acks == 4) begin set_m(0, 0, 11'h0, 0, 4'h0); set_m(1, 0, 11'h0, 0, 4'h0); end
      end
    end
    chk("rr_count", acks, 32'd4);

    // Reset during an m1 write aborts it silently; next tie goes to m0.
    @(posedge clk); #1;
    set_m(1, 1, 11'h400, 1, 4'hE);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_rw",   {31'd0, if1.bus_rw}, 32'd1);
    chk("pre_rst_busy", {31'd0, if1.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rw",   {31'd0, if1.bus_rw}, 32'd0);
    chk("rst_busy", {31'd0, if1.busy}, 32'd0);
    chk("rst_ack",  {31'd0, if1.m1_ack}, 32'd0);
    chk("rst_out",  {if1.bus_addr, if1.bus_data_out, if1.m0_rdata, if1.grant_id}, 32'd0);
    rst = 1'b0;
    set_m(1, 0, 11'h0, 0, 4'h0);
    model_rd = 4'h0;
    repeat (3) @(negedge clk);
    e.id = 1'b0; e.rdata = 4'h6; e.addr = 11'h011;
    q1.push_back(e);
    model_rd = 4'h6;
    set_m(0, 1, 11'h011, 0, 4'h0);
    set_m(1, 1, 11'h022, 0, 4'h0);
    if1.bus_data_in = 4'h6;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_tie_gid", {31'd0, if1.grant_id}, 32'd0);
    @(negedge clk);
    set_m(0, 0, 11'h0, 0, 4'h0);
    set_m(1, 0, 11'h0, 0, 4'h0);
    repeat (3) @(negedge clk);

    // WAIT_CYCLES=3 write: bus_rw high for 3 consecutive cycles, ack 4 cycles after grant.
    @(posedge clk); #1;
    if3.m0_req = 1; if3.m0_addr = 11'h123; if3.m0_rw = 1; if3.m0_wdata = 4'h9;
    @(posedge clk);
    rw_cnt = 0; rw_first = -1; rw_last = -1; ack_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (if3.bus_rw) begin
        rw_cnt++;
        if (rw_first < 0) rw_first = k;
        rw_last = k;
      end
      if (if3.m0_ack && ack_at < 0) begin ack_at = k; if3.m0_req = 0; end
    end
    chk("w3_rw_cnt",   rw_cnt, 32'd3);
    chk("w3_rw_first", rw_first, 32'd1);
    chk("w3_rw_last",  rw_last, 32'd3);
    chk("w3_ack_at",   ack_at, 32'd4);

    // WAIT_CYCLES=3 read: data is sampled in the last wait cycle.
    @(posedge clk); #1;
    if3.m0_req = 1; if3.m0_addr = 11'h050; if3.m0_rw = 0; if3.bus_data_in = 4'h1;
    @(posedge clk);
    ack_at = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) if3.bus_data_in = 4'hC;
      if (if3.m0_ack && ack_at < 0) begin
        ack_at = k;
        chk("w3_rdata", {28'd0, if3.m0_rdata}, 32'hC);
        if3.m0_req = 0;
      end
    end
    chk("w3_rd_ack_at", ack_at, 32'd4);

    repeat (2) @(negedge clk);
    chk("sb_empty", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
